// File: rtl/or_reduce_pkg.sv
// Shared types and constants for the time-shared Or8Way reduction scheduler.
package or_reduce_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam int BEAT_BITS = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/or_reduce_scheduler_if.sv
// Request/result bundle between requesting units, their consumer and the scheduler.
interface or_reduce_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
);
  import or_reduce_pkg::*;

  localparam int ID_W = clog2(NREQ);

  // Valid/ready: a transfer happens on a rising clk edge where valid and ready are
  // both high. Requests use req_ready as a one-cycle acceptance pulse; the result
  // holds res_valid, res_out and res_id unchanged until res_ready is seen.
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  res_valid;
  logic                  res_ready;
  logic                  res_out;
  logic [ID_W-1:0]       res_id;

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_out, res_id
  );

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_out, res_id
  );

endinterface

// File: rtl/Or8Way.sv
// The shared 8-input OR gate chip.
module Or8Way (
  input  logic [7:0] in,
  output logic       out
);

  assign out = |in;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request scanning upward from last_grant+1.
module rr_arbiter
  import or_reduce_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] last_grant,
  output logic [NREQ-1:0] grant_oh,
  output logic [ID_W-1:0] grant_idx,
  output logic            any_req
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest hit overwrites the rest.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    any_req   = |req;
    idx       = 0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = (int'(last_grant) + i) % NREQ;
      if (req[idx]) begin
        grant_oh      = '0;
        grant_oh[idx] = 1'b1;
        grant_idx     = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/or_reduce_scheduler.sv
// Round-robin front end that streams each accepted word through one Or8Way, a byte per cycle.
// Optional OR_REDUCE_EARLY_EXIT_EN: finish as soon as any beat is nonzero.
module or_reduce_scheduler
  import or_reduce_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  or_reduce_scheduler_if.slave  bus,
  output state_e                state
);

  localparam int ID_W   = clog2(NREQ);
  localparam int BEATS  = WIDTH / BEAT_BITS;
  localparam int BEAT_W = clog2(BEATS) + 1;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    data_q;
  logic                acc_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [ID_W-1:0]     id_q;
  logic [ID_W-1:0]     last_q;

  logic [NREQ-1:0]     grant_oh;
  logic [ID_W-1:0]     grant_idx;
  logic                any_req;
  logic [BEAT_BITS-1:0] or8_in;
  logic                or8_out;

  rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .req        (bus.req_valid),
    .last_grant (last_q),
    .grant_oh   (grant_oh),
    .grant_idx  (grant_idx),
    .any_req    (any_req)
  );

  Or8Way u_or8 (
    .in  (or8_in),
    .out (or8_out)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (any_req) state_d = REDUCE;
      REDUCE: begin
        if (beat_q == BEAT_W'(BEATS - 1)) state_d = DONE;
`ifdef OR_REDUCE_EARLY_EXIT_EN
        if (or8_out) state_d = DONE;
`endif
      end
      DONE:   if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // req_ready is gated by reset so a request seen alongside reset is not acknowledged.
  always_comb begin
    bus.req_ready = '0;
    bus.res_valid = 1'b0;
    or8_in        = '0;
    case (state_q)
      IDLE:   if (any_req && !reset) bus.req_ready = grant_oh;
      REDUCE: or8_in = data_q[beat_q*BEAT_BITS +: BEAT_BITS];
      DONE:   bus.res_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.res_out = acc_q;
  assign bus.res_id  = id_q;
  assign state       = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      acc_q  <= 1'b0;
      beat_q <= '0;
      id_q   <= '0;
      last_q <= ID_W'(NREQ - 1);
    end else begin
      case (state_q)
        IDLE: if (any_req) begin
          data_q <= bus.req_data[grant_idx*WIDTH +: WIDTH];
          id_q   <= grant_idx;
          last_q <= grant_idx;
          acc_q  <= 1'b0;
          beat_q <= '0;
        end
        REDUCE: begin
          acc_q  <= acc_q | or8_out;
          beat_q <= beat_q + BEAT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/or_reduce_scheduler.md
# or_reduce_scheduler

Time-shared controller for the single Or8Way reduction chip. It arbitrates round-robin among NREQ requesters, each offering a WIDTH-bit word. The accepted word is streamed through one Or8Way instance, 8 bits per cycle, and the OR-reduced bit is returned on a valid/ready result port. It sits between the requesting datapath units and the shared Or8Way, so one gate chip serves every zero-detect request in the design.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 16, request word width; must be a multiple of 8
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NREQ  bit i: requester i has a word pending
- req_data  in  NREQ*WIDTH  requester i word at [i*WIDTH +: WIDTH]
- req_ready  out  NREQ  one-hot, one-cycle pulse: word of requester i accepted this cycle
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- res_out  out  1  OR of all WIDTH bits of accepted word
- res_id  out  clog2(NREQ)  index of requester the result belongs to

## Operation
- BEATS = WIDTH/8; beat counter width clog2(BEATS)+1.
- States: IDLE, REDUCE, DONE.
- IDLE:
  - If any req_valid bit is set, grant the first set bit scanning upward (with wrap) from last_grant+1.
  - Pulse req_ready[g]. Latch req_data slice g into the data register and g into res_id.
  - Clear acc and beat counter. Set last_grant=g. Go to REDUCE.
- REDUCE:
  - Drive Or8Way.in = data[8*beat +: 8]; LSB byte goes first.
  - Set acc |= Or8Way.out and increment beat.
  - After beat BEATS-1, go to DONE.
- DONE:
  - Hold res_valid=1, res_out=acc, res_id.
  - On res_valid && res_ready, go to IDLE.
  - No request is accepted in the same cycle as the result handshake.
- A requester dropping req_valid after acceptance has no effect. A requester dropping req_valid before a grant is never granted.
- req_ready is 0 in REDUCE and DONE.

## Timing
- Reset values:
  - req_ready=0, res_valid=0, res_out=0, res_id=0.
  - State IDLE, acc=0, beat=0.
  - last_grant=NREQ-1, so requester 0 wins first.
- Latency: acceptance at cycle T. REDUCE occupies T+1..T+BEATS. res_valid rises at T+BEATS+1.
- Throughput: at most one request per BEATS+2 cycles with res_ready held high.
- res_out and res_id are stable throughout DONE. Backpressure is unbounded.
- Reset during REDUCE or DONE abandons the word and emits no result. The requester has already seen req_ready and is not re-served.
- Reset and req_valid in the same cycle: reset wins, and no req_ready is issued.

## Configuration
- OR_REDUCE_EARLY_EXIT_EN:
  - Defined: in REDUCE, if Or8Way.out=1 on any beat, go to DONE next cycle and skip the remaining beats. res_valid then rises at T+k+1, where k is the 1-based index of the first nonzero beat.
  - Undefined: always run all BEATS beats. Latency is fixed at BEATS+1.

## Structure
- Package or_reduce_pkg:
  - State encoding: IDLE=2'd0, REDUCE=2'd1, DONE=2'd2.
  - BEAT_BITS = 8 and the clog2 helper.
- Sub-module rr_arbiter: inputs are the NREQ request vector and last_grant. Outputs are the one-hot grant, the grant index and any_req. It is purely combinational.
- One instance of the existing Or8Way chip. No other reduction logic is allowed in this block.

## Test plan
- Single zero word, NREQ=4, WIDTH=16: reset, then req_valid=4'b0001, req_data[15:0]=16'h0000. Required: req_ready=4'b0001 at T, res_valid at T+3, res_out=0, res_id=0.
- High byte only: req_data[15:0]=16'h0100, macro undefined. Required: res_valid at T+3, res_out=1.
- Early exit: macro defined, word 16'h0001. Required: res_valid at T+2, res_out=1.
- Fairness: req_valid=4'b1111 held, res_ready=1, 5 requests. Required: req_ready order 0001, 0010, 0100, 1000, 0001, and res_id sequence 0,1,2,3,0.
- Backpressure: res_ready=0 for 5 cycles after res_valid. Required: res_valid, res_out and res_id stable, req_ready=0; the handshake completes on the first res_ready=1, and IDLE follows the next cycle.
- Reset mid-REDUCE: assert reset at T+1. Required: the next cycle has res_valid=0 and state IDLE. With req_valid=4'b1010, the next grant goes to requester 1.
